// File: rtl/alram_arb2_pkg.sv
// alram_arb2_pkg: requester ids and read-tag type shared by the arbiter slice
package alram_arb2_pkg;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  typedef struct packed {
    logic vld;
    logic own;
  } tag_t;
endpackage

// File: rtl/alram_arb2_rr_arb2.sv
// rr_arb2: two-way arbiter with selectable fixed priority (A wins) or round-robin
module rr_arb2
  import alram_arb2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       pri_fixed,
  output logic [1:0] gnt
);
  logic ptr;
  logic both;
  // a sole requester always wins; contention goes to A when fixed, else to the pointer
  always_comb begin
    both = &req;
    gnt[0] = req[0] & (!req[1] | pri_fixed | (ptr == REQ_A));
    gnt[1] = req[1] & !gnt[0];
  end
  // pointer flips only on a contended round-robin grant so the loser goes next
  always_ff @(posedge clk)
    ptr <= rst ? REQ_A : (both && !pri_fixed) ? ~ptr : ptr;
endmodule

// File: rtl/alram_arb2.sv
// alram_arb2: shares one 2-cycle-latency RAM between requesters A and B
module alram_arb2
  import alram_arb2_pkg::*;
#(
  parameter int WID  = 256,
  parameter int AWID = 5,
  parameter int RLAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_pri,
  input  logic            a_rreq,
  input  logic [AWID-1:0] a_raddr,
  output logic            a_rgnt,
  output logic            a_rvld,
  output logic [WID-1:0]  a_rdata,
  input  logic            a_wreq,
  input  logic [AWID-1:0] a_waddr,
  input  logic [WID-1:0]  a_wdata,
  output logic            a_wgnt,
  input  logic            b_rreq,
  input  logic [AWID-1:0] b_raddr,
  output logic            b_rgnt,
  output logic            b_rvld,
  output logic [WID-1:0]  b_rdata,
  input  logic            b_wreq,
  input  logic [AWID-1:0] b_waddr,
  input  logic [WID-1:0]  b_wdata,
  output logic            b_wgnt,
  output logic [AWID-1:0] ram_ra,
  input  logic [WID-1:0]  ram_rdo,
  output logic [AWID-1:0] ram_wa,
  output logic [WID-1:0]  ram_wdi,
  output logic            ram_we,
  output logic            busy
);
  logic [1:0] rg, wg;
  logic [AWID-1:0] ra_last;
  tag_t tag [RLAT];
  rr_arb2 u_rd (.clk(clk), .rst(rst), .req({b_rreq, a_rreq}), .pri_fixed(cfg_pri), .gnt(rg));
  rr_arb2 u_wr (.clk(clk), .rst(rst), .req({b_wreq, a_wreq}), .pri_fixed(cfg_pri), .gnt(wg));
  // grant fan-out, RAM muxing and read return decode; rvld is masked while in reset
  always_comb begin
    a_rgnt = rg[0];
    b_rgnt = rg[1];
    a_wgnt = wg[0];
    b_wgnt = wg[1];
    ram_ra = rg[0] ? a_raddr : rg[1] ? b_raddr : ra_last;
    ram_we = |wg;
    ram_wa = wg[1] ? b_waddr : a_waddr;
    ram_wdi = wg[1] ? b_wdata : a_wdata;
    a_rdata = ram_rdo;
    b_rdata = ram_rdo;
    a_rvld = tag[RLAT-1].vld & (tag[RLAT-1].own == REQ_A) & !rst;
    b_rvld = tag[RLAT-1].vld & (tag[RLAT-1].own == REQ_B) & !rst;
    busy = 1'b0;
    for (int i = 0; i < RLAT; i++) busy = busy | tag[i].vld;
  end
  // held read address and owner tag shift register matched to the RAM latency
  always_ff @(posedge clk) begin
    ra_last <= rst ? '0 : ram_ra;
    tag[0] <= rst ? '0 : tag_t'{vld: |rg, own: rg[1]};
    for (int i = 1; i < RLAT; i++) tag[i] <= rst ? '0 : tag[i-1];
  end
endmodule
